// File: rtl/ps2_rx_pkg.sv
// Shared PS/2 receiver definitions: FSM states, frame constants, parity helper.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_LVL = 1'b0;
  localparam logic        STOP_LVL  = 1'b1;

  // Odd parity holds when the data bits plus the parity bit contain an odd number of ones.
  function automatic logic parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus a level filter for the keyboard clock; reports filtered falling edges.
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic fall
);

  localparam int unsigned CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  // The flip happens on the same edge the counter would reach FILTER_LEN-1, so the
  // filtered level moves FILTER_LEN cycles after stage 1 first captures the change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_s1      <= in;
      r_s2      <= r_s1;
      r_level_d <= r_level;
      if (r_s2 != r_level) begin
        if (r_cnt == CW'(FILTER_LEN - 2)) begin
          r_level <= r_s2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign out  = r_level;
  assign fall = ~r_level & r_level_d;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: filtered clock edges drive an 11-bit frame deserialiser.
module ps2_rx
  import ps2_rx_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_ready,
  output logic       frame_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic w_clk_filt;
  logic w_clk_fall;
  logic w_edge;
  logic w_timeout;

  logic          r_d1;
  logic          r_d2;
  state_t        r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_cnt;
  logic          r_par;
  logic [TW-1:0] r_to;
  logic [7:0]    r_code;
  logic          r_ready;
  logic          r_err;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .in    (ps2_clk),
    .out   (w_clk_filt),
    .fall  (w_clk_fall)
  );

  assign w_edge    = w_clk_fall & ~w_clk_filt;
  assign w_timeout = (r_to == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d1 <= 1'b1;
      r_d2 <= 1'b1;
    end else begin
      r_d1 <= ps2_data;
      r_d2 <= r_d1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_to    <= '0;
      r_code  <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;

      if (w_edge || r_state == ST_IDLE) begin
        r_to <= '0;
      end else if (!w_timeout) begin
        r_to <= r_to + TW'(1);
      end

      // An edge takes priority over a simultaneous timeout.
      if (w_edge) begin
        unique case (r_state)
          ST_IDLE: begin
            if (r_d2 == START_LVL) begin
              r_state <= ST_DATA;
              r_cnt   <= '0;
            end
          end
          ST_DATA: begin
            r_shift <= {r_d2, r_shift[7:1]};
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'(DATA_BITS - 1)) begin
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            r_par   <= r_d2;
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            if (r_d2 == STOP_LVL && parity_ok(r_shift, r_par)) begin
              r_code  <= r_shift;
              r_ready <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (r_state != ST_IDLE && w_timeout) begin
        r_state <= ST_IDLE;
        r_shift <= '0;
        r_cnt   <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign scan_code   = r_code;
  assign scan_ready  = r_ready;
  assign frame_error = r_err;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: tabled frames, directed corner cases, random frames vs a byte-level model.
module tb_ps2_rx;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 600;
  localparam int unsigned HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_ready;
  logic       frame_error;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_ready = 0;
  int unsigned n_err = 0;
  int unsigned n_overlap = 0;
  int unsigned n_wide = 0;
  int unsigned last_ready_cyc = 0;
  int unsigned last_err_cyc = 0;
  int unsigned last_t0 = 0;
  logic        prev_ready = 1'b0;
  logic        prev_err = 1'b0;
  logic [7:0]  model_code = 8'h00;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic       exp_ready;
    logic       exp_err;
    logic [7:0] exp_code;
  } vec_t;

  vec_t tbl[8];

  ps2_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .scan_code   (scan_code),
    .scan_ready  (scan_ready),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (scan_ready && frame_error) n_overlap++;
    if ((scan_ready && prev_ready) || (frame_error && prev_err)) n_wide++;
    if (scan_ready) begin
      n_ready++;
      last_ready_cyc = cyc;
    end
    if (frame_error) begin
      n_err++;
      last_err_cyc = cyc;
    end
    prev_ready = scan_ready;
    prev_err   = frame_error;
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    last_t0 = cyc + 1;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] frame, input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++) send_bit(frame[i]);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic par, input logic stop,
                           input logic exp_ready, input logic exp_err, input logic [7:0] exp_code);
    int unsigned r0, e0;
    r0 = n_ready;
    e0 = n_err;
    send_bits({stop, par, d, 1'b0}, 11);
    tick(FL + 6);
    check("ready_count", n_ready - r0, 32'(exp_ready));
    check("error_count", n_err - e0, 32'(exp_err));
    check("scan_code", 32'(scan_code), 32'(exp_code));
    if (exp_ready) check("ready_latency", last_ready_cyc, last_t0 + FL + 1);
    if (exp_err)   check("error_latency", last_err_cyc, last_t0 + FL + 1);
  endtask

  initial begin
    int unsigned r0, e0, lo, hi;
    logic [7:0]  d;
    logic        par, stop, good;

    tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C};
    tbl[1] = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hF0};
    tbl[2] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C};
    tbl[3] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C};
    tbl[4] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C};
    tbl[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 8'h80};

    tick(5);
    check("reset_code", 32'(scan_code), 0);
    check("reset_ready", 32'(scan_ready), 0);
    check("reset_error", 32'(frame_error), 0);
    reset = 1'b0;
    tick(10);

    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].d, tbl[i].par, tbl[i].stop, tbl[i].exp_ready, tbl[i].exp_err, tbl[i].exp_code);
    end
    model_code = 8'h80;

    // Timeout: start + 4 data bits, then the clock stays high.
    r0 = n_ready;
    e0 = n_err;
    send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5);
    tick(TO + 10 + FL);
    check("timeout_error_count", n_err - e0, 1);
    check("timeout_ready_count", n_ready - r0, 0);
    lo = last_t0 + FL + TO;
    hi = last_t0 + FL + TO + 3;
    check("timeout_window", 32'(last_err_cyc >= lo && last_err_cyc <= hi), 1);
    run_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A);

    // Glitch rejection: clock low for FL-2 cycles with data low in IDLE.
    r0 = n_ready;
    e0 = n_err;
    ps2_data = 1'b0;
    tick(2);
    ps2_clk = 1'b0;
    tick(FL - 2);
    ps2_clk = 1'b1;
    tick(30);
    ps2_data = 1'b1;
    tick(HALF * 3);
    check("glitch_no_pulse", (n_ready - r0) + (n_err - e0), 0);
    run_frame(8'h29, 1'b0, 1'b1, 1'b1, 1'b0, 8'h29);

    // Reset after 6 data bits.
    e0 = n_err;
    send_bits({1'b1, 1'b1, 8'hC3, 1'b0}, 7);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midreset_code", 32'(scan_code), 0);
    check("midreset_ready", 32'(scan_ready), 0);
    check("midreset_error", 32'(frame_error), 0);
    tick(HALF * 3);
    run_frame(8'h16, 1'b0, 1'b1, 1'b1, 1'b0, 8'h16);
    check("midreset_no_error", n_err - e0, 0);
    model_code = 8'h16;

    // Random frames against the byte-level model.
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom_range(0, 255));
      par  = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 7) != 0);
      good = stop && ((($countones(d) + 32'(par)) % 2) == 1);
      if (good) model_code = d;
      run_frame(d, par, stop, good, !good, model_code);
      tick($urandom_range(0, 20));
    end

    check("never_overlap", n_overlap, 0);
    check("single_cycle_pulses", n_wide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
